dac_spi_writer: RTL and testbench
=================================

Name: dac_spi_writer

Overview:
- SPI write-only master for the board's 4-channel 12-bit serial DAC (LTC2624 class); the output-side counterpart of the ADC-reading SPI controller.
- Accepts one {address, 12-bit code} word per valid/ready handshake and shifts out one 32-bit frame with chip-select framing.
- Sits between the control datapath (PID output / setpoint monitor) and the DAC pins, replacing the tied-off DAC_CS.

Parameters:
- CLK_DIV, 2, clk cycles per SCK half-period; legal range ≥1.
- CMD, 4'b0011, DAC command nibble (write and update).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- din_valid  input  1  request to send a word
- din_ready  output  1  block can accept a word this cycle
- din_addr  input  4  DAC channel address (4'hF = all channels)
- din_data  input  12  DAC code
- busy  output  1  frame in progress, CS low or CS-high guard
- done  output  1  one-cycle pulse at end of frame
- MOSI  output  1  serial data to DAC
- SPI_CLK  output  1  serial clock
- DAC_CS  output  1  DAC chip select, active low
- DAC_CLR  output  1  DAC asynchronous clear, active low

Behaviour:
- Reset (rst=0, async): DAC_CS=1, SPI_CLK=0, MOSI=0, din_ready=0, busy=0, done=0, DAC_CLR=0. After release: DAC_CLR=1 from the first clk edge, din_ready=1.
- Frame layout, MSB first: [31:24]=8'h00, [23:20]=CMD, [19:16]=addr, [15:4]=data, [3:0]=4'h0.
- Handshake: transfer occurs on an edge with din_valid & din_ready. addr and data are captured into a 32-bit shift register at that edge. Inputs are ignored while din_ready=0.
- States:
  - IDLE: din_ready=1. Handshake -> SHIFT.
  - SHIFT: DAC_CS=0. 32 bits. Each bit is CLK_DIV cycles with SPI_CLK=0, then CLK_DIV cycles with SPI_CLK=1. MOSI updates only at the start of each low phase, so the DAC samples on the rising edge. After bit 0's high phase -> TAIL.
  - TAIL: SPI_CLK=0, DAC_CS=0 for CLK_DIV cycles -> GUARD.
  - GUARD: DAC_CS=1 for CLK_DIV cycles. done=1 in the first GUARD cycle only. -> IDLE.
- Timing: handshake at edge N, so DAC_CS falls after edge N. DAC_CS stays low for 65*CLK_DIV cycles (130 cycles at CLK_DIV=2). din_ready returns after a further CLK_DIV cycles.
- busy=1 in SHIFT, TAIL and GUARD. din_ready = (state==IDLE) & rst-released.
- Back-to-back: din_valid held high starts the next frame on the first IDLE cycle. Minimum CS-high time is CLK_DIV+1 cycles.
- Reset mid-frame aborts immediately: DAC_CS=1 asynchronously, no done pulse, and the partial frame is discarded (the DAC ignores frames with fewer than 24 clocks latched). The DAC channel state after a reset mid-frame is undefined, which is acceptable because DAC_CLR is asserted.
- Counters: a half-period counter of width clog2(CLK_DIV)+1 and a 5-bit bit counter with no wrap hazard. CLK_DIV=0 is illegal; the block shall raise a simulation-time $error on CLK_DIV=0.

Optional Feature:
- Macro DAC_SIGNED_IN_EN.
- Defined: din_data is two's complement. The block converts it to offset binary by inverting bit 11 at capture: 12'h800 (-2048) -> 12'h000, 12'h000 -> 12'h800, 12'h7FF -> 12'hFFF.
- Undefined: din_data is sent unmodified as straight binary.

Decomposition:
- Package dac_spi_pkg:
  - state enum {IDLE, SHIFT, TAIL, GUARD}
  - FRAME_W=32, DATA_W=12, ADDR_W=4
  - CMD_WRITE_UPDATE=4'b0011, CMD_POWER_DOWN=4'b0100, ADDR_ALL=4'hF
- One natural sub-module, spi_sck_gen: the half-period counter. It emits fall_tick/rise_tick and SPI_CLK level, and is enabled only in SHIFT. It is reusable by the ADC controller.

Test Plan:
- Reset held, then released -> DAC_CS=1, SPI_CLK=0, MOSI=0, DAC_CLR=0 during reset. After release: DAC_CLR=1 and din_ready=1 on the first edge.
- CLK_DIV=2, addr=4'h0, data=12'hABC -> bits sampled on SPI_CLK rising = 32'h0030ABC0. Exactly 32 rising edges. DAC_CS low 130 cycles. done single pulse. din_ready back 2 cycles later.
- din_valid held for two words (12'h001 then 12'hFFF, addr 4'hF) -> two frames 32'h003F0010 and 32'h003FFFF0, with DAC_CS high ≥3 cycles between them.
- din_valid pulsed with data=12'h555 mid-frame -> ignored. The current frame is unchanged and no second frame is sent.
- rst asserted during bit 10 -> DAC_CS=1 and SPI_CLK=0 in the same cycle (async), no done pulse. After release, frame with data=12'h123 is correct (32'h00301230).
- DAC_SIGNED_IN_EN defined: data=12'h800 -> frame data 12'h000; data=12'h7FF -> 12'hFFF.

Source files
------------

// File: rtl/dac_spi_pkg.sv
// dac_spi_pkg: shared state type, frame geometry and DAC command constants
// for the DAC SPI writer and its SCK generator.
package dac_spi_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, TAIL, GUARD} state_t;
    localparam int FRAME_W = 32;
    localparam int DATA_W = 12;
    localparam int ADDR_W = 4;
    localparam logic [3:0] CMD_WRITE_UPDATE = 4'b0011;
    localparam logic [3:0] CMD_POWER_DOWN = 4'b0100;
    localparam logic [ADDR_W-1:0] ADDR_ALL = 4'hF;
    function automatic logic [FRAME_W-1:0] build_frame(input logic [3:0] cmd,
                                                       input logic [ADDR_W-1:0] addr,
                                                       input logic [DATA_W-1:0] code);
        return {8'h00, cmd, addr, code, 4'h0};
    endfunction
endpackage

// File: rtl/spi_sck_gen.sv
// spi_sck_gen: half-period counter producing an SPI clock that idles low.
// Ports: clk, rst (async active-low), en (run; low forces idle),
//        sck (registered SPI clock), rise_tick/fall_tick (high on the clk
//        edge where sck goes high/low).
module spi_sck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sck,
    output logic rise_tick,
    output logic fall_tick
);
    localparam int CW = $clog2(CLK_DIV) + 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
    logic [CW-1:0] cnt;
    logic wrap;
    assign wrap = en && cnt == LAST;
    assign rise_tick = wrap && !sck;
    assign fall_tick = wrap && sck;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (wrap) begin
            cnt <= '0;
            sck <= ~sck;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/dac_spi_writer.sv
// dac_spi_writer: write-only SPI master sending one 32-bit frame per
// {address, 12-bit code} handshake to an LTC2624-class DAC.
// Ports: clk, rst (async active-low), din_valid/din_ready/din_addr/din_data
//        (input word handshake), busy, done (end-of-frame pulse),
//        MOSI, SPI_CLK, DAC_CS (active low), DAC_CLR (active low).
// Build option: DAC_SIGNED_IN_EN treats din_data as two's complement and
// converts it to offset binary at capture.
module dac_spi_writer
    import dac_spi_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter logic [3:0] CMD = CMD_WRITE_UPDATE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic [ADDR_W-1:0] din_addr,
    input  logic [DATA_W-1:0] din_data,
    output logic              busy,
    output logic              done,
    output logic              MOSI,
    output logic              SPI_CLK,
    output logic              DAC_CS,
    output logic              DAC_CLR
);
    localparam int CW = $clog2(CLK_DIV) + 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    if (CLK_DIV < 1) begin : g_bad_div
        always_ff @(posedge clk) $error("dac_spi_writer: CLK_DIV must be >= 1");
    end

    state_t             state;
    logic [FRAME_W-2:0] shreg;
    logic [4:0]         bitcnt;
    logic               last;
    logic [CW-1:0]      wcnt;
    logic               rise_tick, fall_tick;
    logic [DATA_W-1:0]  code;
    logic [FRAME_W-1:0] frame;

`ifdef DAC_SIGNED_IN_EN
    assign code = {~din_data[DATA_W-1], din_data[DATA_W-2:0]};
`else
    assign code = din_data;
`endif
    assign frame = build_frame(CMD, din_addr, code);

    spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
        .clk       (clk),
        .rst       (rst),
        .en        (state == SHIFT),
        .sck       (SPI_CLK),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    // MSB goes out with the handshake; later bits change on SCK falls so the
    // DAC sees stable data at each rising edge. 'last' marks that bit 0 has
    // been clocked, so its falling edge ends the shift phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            shreg     <= '0;
            bitcnt    <= '0;
            last      <= 1'b0;
            wcnt      <= '0;
            MOSI      <= 1'b0;
            DAC_CS    <= 1'b1;
            din_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            DAC_CLR   <= 1'b0;
        end else begin
            DAC_CLR <= 1'b1;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (din_valid && din_ready) begin
                        state     <= SHIFT;
                        shreg     <= frame[FRAME_W-2:0];
                        MOSI      <= frame[FRAME_W-1];
                        bitcnt    <= 5'd31;
                        last      <= 1'b0;
                        DAC_CS    <= 1'b0;
                        din_ready <= 1'b0;
                        busy      <= 1'b1;
                    end else begin
                        din_ready <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (rise_tick) last <= (bitcnt == 5'd0);
                    if (fall_tick) begin
                        if (last) begin
                            state <= TAIL;
                            MOSI  <= 1'b0;
                            wcnt  <= '0;
                        end else begin
                            MOSI   <= shreg[FRAME_W-2];
                            shreg  <= {shreg[FRAME_W-3:0], 1'b0};
                            bitcnt <= bitcnt - 5'd1;
                        end
                    end
                end
                TAIL: begin
                    if (wcnt == LAST) begin
                        state  <= GUARD;
                        wcnt   <= '0;
                        DAC_CS <= 1'b1;
                        done   <= 1'b1;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                GUARD: begin
                    if (wcnt == LAST) begin
                        state     <= IDLE;
                        wcnt      <= '0;
                        busy      <= 1'b0;
                        din_ready <= 1'b1;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dac_spi_writer.sv
// tb_dac_spi_writer: directed self-checking bench for dac_spi_writer.
module tb_dac_spi_writer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        din_valid = 1'b0;
    logic [3:0]  din_addr = '0;
    logic [11:0] din_data = '0;
    logic        din_ready, busy, done, MOSI, SPI_CLK, DAC_CS, DAC_CLR;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] data;
        int          n;
    } frame_t;

    frame_t      got_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] cap = '0;
    int          nbits = 0;
    int          done_cnt = 0;

    dac_spi_writer #(.CLK_DIV(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .din_addr  (din_addr),
        .din_data  (din_data),
        .busy      (busy),
        .done      (done),
        .MOSI      (MOSI),
        .SPI_CLK   (SPI_CLK),
        .DAC_CS    (DAC_CS),
        .DAC_CLR   (DAC_CLR)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    always @(negedge DAC_CS) begin
        cap = '0;
        nbits = 0;
    end
    always @(posedge SPI_CLK) if (DAC_CS === 1'b0) begin
        cap = {cap[30:0], MOSI};
        nbits++;
    end
    always @(posedge DAC_CS) got_q.push_back('{cap, nbits});
    always @(negedge clk) if (done === 1'b1) done_cnt++;

    function automatic logic [31:0] model(input logic [3:0] a, input logic [11:0] d);
`ifdef DAC_SIGNED_IN_EN
        d = d ^ 12'h800;
`endif
        return {8'h00, 4'b0011, a, d, 4'h0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] a, input logic [11:0] d, input bit expect_it);
        int t = 0;
        while (din_ready !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("ready_wait", t < 500, 1'b1);
        din_valid = 1'b1;
        din_addr = a;
        din_data = d;
        if (expect_it) exp_q.push_back(model(a, d));
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    task automatic wait_frame(input string tag, input int exp_low);
        int low = 0;
        int guard = 0;
        int d0 = done_cnt;
        while (DAC_CS === 1'b0 && low < 2000) begin
            @(negedge clk);
            low++;
        end
        chk({tag, "_cs_low"}, low, exp_low);
        chk({tag, "_done_first"}, done, 1'b1);
        while (din_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, "_ready_gap"}, guard, 2);
        chk({tag, "_done_cnt"}, done_cnt - d0, 1);
    endtask

    task automatic check_frame(input string tag);
        frame_t      f;
        logic [31:0] e;
        chk({tag, "_avail"}, got_q.size() > 0 && exp_q.size() > 0, 1'b1);
        if (got_q.size() > 0 && exp_q.size() > 0) begin
            f = got_q.pop_front();
            e = exp_q.pop_front();
            chk(tag, f.data, e);
            chk({tag, "_bits"}, f.n, 32);
        end
    endtask

    initial begin
        int     t;
        int     gap;
        int     d0;
        frame_t f;
        repeat (3) @(negedge clk);
        chk("rst_cs", DAC_CS, 1'b1);
        chk("rst_sck", SPI_CLK, 1'b0);
        chk("rst_mosi", MOSI, 1'b0);
        chk("rst_clr", DAC_CLR, 1'b0);
        chk("rst_ready", din_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        got_q.delete();
        rst = 1'b1;
        @(negedge clk);
        chk("rel_clr", DAC_CLR, 1'b1);
        chk("rel_ready", din_ready, 1'b1);

        send(4'h0, 12'hABC, 1);
        chk("a_cs_fall", DAC_CS, 1'b0);
        chk("a_busy", busy, 1'b1);
        chk("a_ready_low", din_ready, 1'b0);
        wait_frame("a", 130);
        check_frame("a_frame");
        chk("a_literal", model(4'h0, 12'hABC), 32'h0030ABC0);

        d0 = done_cnt;
        din_valid = 1'b1;
        din_addr = 4'hF;
        din_data = 12'h001;
        exp_q.push_back(model(4'hF, 12'h001));
        @(negedge clk);
        din_data = 12'hFFF;
        exp_q.push_back(model(4'hF, 12'hFFF));
        t = 0;
        while (DAC_CS === 1'b0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        gap = 0;
        while (DAC_CS === 1'b1 && gap < 100) begin
            @(negedge clk);
            gap++;
        end
        din_valid = 1'b0;
        chk("b2b_cs_high", gap, 3);
        wait_frame("b2b", 130);
        chk("b2b_done_total", done_cnt - d0, 2);
        check_frame("b2b_first");
        check_frame("b2b_second");

        send(4'h1, 12'h3C5, 1);
        repeat (20) @(negedge clk);
        din_valid = 1'b1;
        din_addr = 4'h2;
        din_data = 12'h555;
        @(negedge clk);
        din_valid = 1'b0;
        wait_frame("ign", 109);
        check_frame("ign_frame");
        repeat (30) @(negedge clk);
        chk("ign_no_extra", got_q.size(), 0);
        chk("ign_cs_idle", DAC_CS, 1'b1);
        chk("ign_busy", busy, 1'b0);

        send(4'h2, 12'h3A5, 0);
        t = 0;
        while (nbits < 22 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("abort_bit10", nbits, 22);
        d0 = done_cnt;
        #2 rst = 1'b0;
        #1;
        chk("abort_cs", DAC_CS, 1'b1);
        chk("abort_sck", SPI_CLK, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_ready", din_ready, 1'b0);
        chk("abort_clr", DAC_CLR, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_partial_seen", got_q.size(), 1);
        if (got_q.size() > 0) begin
            f = got_q.pop_front();
            chk("abort_partial_bits", f.n, 22);
        end
        send(4'h0, 12'h123, 1);
        wait_frame("post", 130);
        check_frame("post_frame");

        send(4'h0, 12'h800, 1);
        wait_frame("neg", 130);
        check_frame("neg_frame");
        send(4'h0, 12'h7FF, 1);
        wait_frame("pos", 130);
        check_frame("pos_frame");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
